// File: rtl/multi_led_cal_pkg.sv
// Shared FSM/phase encodings and the window average helper for the LED calibrator.
// Pure declarations: no latency, no flow control.
package multi_led_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEAS,
    DC_ADJ,
    PGA_ADJ,
    NEXT_CH,
    OPERATE
  } state_t;

  typedef enum logic {
    DC,
    PGA
  } phase_t;

  localparam int AVG_W = 16;

  // Midpoint of two codes, summed one bit wider so the carry is never lost.
  function automatic logic [AVG_W-1:0] avg_of(input logic [AVG_W-1:0] lo,
                                               input logic [AVG_W-1:0] hi);
    logic [AVG_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[AVG_W:1];
  endfunction

endpackage

// File: rtl/multi_led_calibrator_window.sv
// Min/max tracker over WIN_SAMPLES strobed samples; results registered, done one cycle after the last sample.
// No backpressure: a low sample_en simply stalls the window until clear.
module window_minmax #(
  parameter int ADC_W       = 8,
  parameter int WIN_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [ADC_W-1:0] adc,
  output logic [ADC_W-1:0] min_val,
  output logic [ADC_W-1:0] max_val,
  output logic             done
);

  localparam int CNT_W = $clog2(WIN_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_SAMPLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_val <= '0;
      max_val <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else if (clear) begin
      min_val <= '1;
      max_val <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else if (sample_en && !done) begin
      if (adc < min_val) min_val <= adc;
      if (adc > max_val) max_val <= adc;
      cnt  <= cnt + 1'b1;
      done <= (cnt == LAST);
    end
  end

endmodule

// File: rtl/multi_led_calibrator.sv
// Per-channel DC/PGA calibration followed by round-robin LED slots; find_setting acts on the next cycle.
// No backpressure: measurement waits on sample_en, operation samples are reported once per slot.
module multi_led_calibrator
  import multi_led_cal_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADC_W       = 8,
  parameter int DC_W        = 7,
  parameter int PGA_W       = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int WIN_SAMPLES = 8,
  parameter int SLOT_CYC    = 10,
  parameter int TARGET_LO   = 120,
  parameter int TARGET_HI   = 130,
  parameter int CLIP_LO     = 10,
  parameter int CLIP_HI     = 245
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [ADC_W-1:0]          ADC,
  input  logic                      sample_en,
  input  logic                      find_setting,
  output logic [NUM_CH-1:0]         led_en,
  output logic [DC_W-1:0]           dc_comp,
  output logic [PGA_W-1:0]          pga_gain,
  output logic                      busy,
  output logic                      cal_done,
  output logic                      ch_valid,
  output logic [$clog2(NUM_CH)-1:0] ch_id,
  output logic [ADC_W-1:0]          ch_value,
  output logic [NUM_CH*DC_W-1:0]    ch_dc,
  output logic [NUM_CH*PGA_W-1:0]   ch_pga,
  output logic [NUM_CH-1:0]         ch_sat,
  output logic [NUM_CH-1:0]         ch_clip0
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(SLOT_CYC + 1);
  localparam int IT_W  = DC_W + 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  ACC_FIRST   = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  REPORT_CYC  = CNT_W'(SLOT_CYC - 2);
  localparam logic [CNT_W-1:0]  SLOT_LAST   = CNT_W'(SLOT_CYC - 1);
  localparam logic [IT_W-1:0]   ITER_CAP    = IT_W'(2 ** DC_W);
  localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic [ADC_W-1:0]  T_LO        = ADC_W'(TARGET_LO);
  localparam logic [ADC_W-1:0]  T_HI        = ADC_W'(TARGET_HI);
  localparam logic [ADC_W-1:0]  C_LO        = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0]  C_HI        = ADC_W'(CLIP_HI);

  state_t           state;
  phase_t           phase;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] cnt;
  logic [IT_W-1:0]  iter;
  logic [ADC_W-1:0] avg;
  logic             clip;
  logic [ADC_W-1:0] last_smp;
  logic             got;

  logic [ADC_W-1:0] win_min;
  logic [ADC_W-1:0] win_max;
  logic             win_done;
  logic [ADC_W-1:0] avg_now;
  logic             clip_now;
  logic [CH_W-1:0]  ch_nxt;
  logic             acc;

  window_minmax #(
    .ADC_W       (ADC_W),
    .WIN_SAMPLES (WIN_SAMPLES)
  ) u_window (
    .clk       (CLK),
    .rst       (rst),
    .clear     (state != MEAS),
    .sample_en (sample_en),
    .adc       (ADC),
    .min_val   (win_min),
    .max_val   (win_max),
    .done      (win_done)
  );

  assign avg_now  = ADC_W'(avg_of(AVG_W'(win_min), AVG_W'(win_max)));
  assign clip_now = (win_min < C_LO) || (win_max > C_HI);
  assign ch_nxt   = (ch == CH_LAST) ? '0 : ch + 1'b1;
  // The report is registered into the final slot cycle, so that cycle's own sample cannot be included.
  assign acc      = sample_en && (cnt >= ACC_FIRST) && (cnt <= REPORT_CYC);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= DC;
      ch       <= '0;
      cnt      <= '0;
      iter     <= '0;
      avg      <= '0;
      clip     <= 1'b0;
      last_smp <= '0;
      got      <= 1'b0;
      led_en   <= '0;
      dc_comp  <= '0;
      pga_gain <= '0;
      busy     <= 1'b0;
      cal_done <= 1'b0;
      ch_valid <= 1'b0;
      ch_id    <= '0;
      ch_value <= '0;
      ch_dc    <= '0;
      ch_pga   <= '0;
      ch_sat   <= '0;
      ch_clip0 <= '0;
    end else if (find_setting) begin
      state    <= SETTLE;
      phase    <= DC;
      ch       <= '0;
      cnt      <= '0;
      iter     <= '0;
      got      <= 1'b0;
      led_en   <= NUM_CH'(1);
      dc_comp  <= '0;
      pga_gain <= '0;
      busy     <= 1'b1;
      cal_done <= 1'b0;
      ch_valid <= 1'b0;
    end else begin
      ch_valid <= 1'b0;
      case (state)
        IDLE: ;
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= MEAS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEAS: begin
          if (win_done) begin
            avg   <= avg_now;
            clip  <= clip_now;
            state <= (phase == DC) ? DC_ADJ : PGA_ADJ;
          end
        end
        DC_ADJ: begin
          if (avg < T_LO && dc_comp != '0 && iter != ITER_CAP) begin
            dc_comp <= dc_comp - 1'b1;
            iter    <= iter + 1'b1;
            state   <= SETTLE;
          end else if (avg > T_HI && dc_comp != '1 && iter != ITER_CAP) begin
            dc_comp <= dc_comp + 1'b1;
            iter    <= iter + 1'b1;
            state   <= SETTLE;
          end else begin
            // In band, pinned at a code limit, or out of iterations: keep the code, tune gain next.
            ch_dc[ch*DC_W +: DC_W] <= dc_comp;
            ch_sat[ch]             <= (avg < T_LO) || (avg > T_HI);
            pga_gain               <= '0;
            phase                  <= PGA;
            state                  <= SETTLE;
          end
        end
        PGA_ADJ: begin
          if (clip || pga_gain == '1) begin
            ch_pga[ch*PGA_W +: PGA_W] <= (clip && pga_gain != '0) ? pga_gain - 1'b1 : pga_gain;
            ch_clip0[ch]              <= clip && (pga_gain == '0);
            state                     <= NEXT_CH;
          end else begin
            pga_gain <= pga_gain + 1'b1;
            state    <= SETTLE;
          end
        end
        NEXT_CH: begin
          if (ch != CH_LAST) begin
            ch       <= ch_nxt;
            led_en   <= NUM_CH'(1) << ch_nxt;
            dc_comp  <= '0;
            pga_gain <= '0;
            phase    <= DC;
            iter     <= '0;
            state    <= SETTLE;
          end else begin
            ch       <= '0;
            led_en   <= NUM_CH'(1);
            dc_comp  <= ch_dc[DC_W-1:0];
            pga_gain <= ch_pga[PGA_W-1:0];
            busy     <= 1'b0;
            cal_done <= 1'b1;
            cnt      <= '0;
            got      <= 1'b0;
            state    <= OPERATE;
          end
        end
        OPERATE: begin
          if (acc) begin
            last_smp <= ADC;
            got      <= 1'b1;
          end
          if (cnt == REPORT_CYC && (got || acc)) begin
            ch_valid <= 1'b1;
            ch_id    <= ch;
            ch_value <= acc ? ADC : last_smp;
          end
          if (cnt == SLOT_LAST) begin
            cnt      <= '0;
            got      <= 1'b0;
            ch       <= ch_nxt;
            led_en   <= NUM_CH'(1) << ch_nxt;
            dc_comp  <= ch_dc[ch_nxt*DC_W +: DC_W];
            pga_gain <= ch_pga[ch_nxt*PGA_W +: PGA_W];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_led_calibrator.sv
// Bench: table of calibration scenarios against an analog front-end model, randomized operation slots, NUM_CH=4 regression.
module tb_multi_led_calibrator;

  localparam int SLOT = 10;
  localparam int SET  = 4;
  localparam int M_FLAT = 0, M_SQ20 = 1, M_SQ120 = 2, M_C50 = 3, M_RAND = 4;

  logic CLK = 1'b0;
  logic rst, sample_en, find_setting;
  logic [7:0] adc2, adc4, rand_adc;
  int   mode;
  int   base [4];
  bit   tog;

  logic [1:0]  led2;  logic [6:0] dc2;  logic [3:0] pga2;
  logic        busy2, done2, vld2;  logic [0:0] id2;  logic [7:0] val2;
  logic [13:0] chdc2; logic [7:0] chpga2; logic [1:0] sat2, clip2;

  logic [3:0]  led4;  logic [6:0] dc4;  logic [3:0] pga4;
  logic        busy4, done4, vld4;  logic [1:0] id4;  logic [7:0] val4;
  logic [27:0] chdc4; logic [15:0] chpga4; logic [3:0] sat4, clip4;

  multi_led_calibrator dut2 (
    .CLK(CLK), .rst(rst), .ADC(adc2), .sample_en(sample_en), .find_setting(find_setting),
    .led_en(led2), .dc_comp(dc2), .pga_gain(pga2), .busy(busy2), .cal_done(done2),
    .ch_valid(vld2), .ch_id(id2), .ch_value(val2), .ch_dc(chdc2), .ch_pga(chpga2),
    .ch_sat(sat2), .ch_clip0(clip2));

  multi_led_calibrator #(.NUM_CH(4)) dut4 (
    .CLK(CLK), .rst(rst), .ADC(adc4), .sample_en(sample_en), .find_setting(find_setting),
    .led_en(led4), .dc_comp(dc4), .pga_gain(pga4), .busy(busy4), .cal_done(done4),
    .ch_valid(vld4), .ch_id(id4), .ch_value(val4), .ch_dc(chdc4), .ch_pga(chpga4),
    .ch_sat(sat4), .ch_clip0(clip4));

  initial forever #5 CLK = ~CLK;

  // Front-end model: what the ADC would read for the LED, DC code and gain currently applied.
  function automatic logic [7:0] model(input int m, input logic [3:0] led, input logic [6:0] dc,
                                       input logic [3:0] g, input bit t);
    int c, v, sw;
    c = 0;
    for (int i = 0; i < 4; i++) if (led[i]) c = i;
    case (m)
      M_FLAT:  v = base[c] - int'(dc);
      M_SQ20:  begin sw = 20 * int'(g);        v = t ? 125 + sw : 125 - sw; end
      M_SQ120: begin sw = 120 * (int'(g) + 1); v = t ? 125 + sw : 125 - sw; end
      default: v = 50;
    endcase
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  always @(negedge CLK) begin
    tog  = ~tog;
    adc2 = (mode == M_RAND) ? rand_adc : model(mode, {2'b00, led2}, dc2, pga2, tog);
    adc4 = (mode == M_RAND) ? rand_adc : model(mode, led4, dc4, pga4, tog);
  end

  int checks, errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic start_cal();
    rst = 1'b1; tick(2);
    rst = 1'b0; find_setting = 1'b1; tick();
    find_setting = 1'b0;
  endtask

  task automatic wait_done(input bit four, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      tick();
      if ((four ? done4 : done2) === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cal_done_timeout actual=0 expected=1 (four=%0d)", four);
    end
  endtask

  function automatic int exp_dc(input int b);
    return (b > 130) ? b - 130 : 0;
  endfunction

  typedef struct {
    int          mode;
    int          b0;
    int          b1;
    logic [13:0] dc;
    logic [7:0]  pga;
    logic [1:0]  sat;
    logic [1:0]  clip;
  } vec_t;

  vec_t vt [6];
  logic [7:0] acc_q [$];

  initial begin
    bit ok;
    int r0, r1, slot, pos, c;
    bit exp_v;

    vt[0] = '{M_FLAT,  150, 150, {7'd20, 7'd20}, {4'd15, 4'd15}, 2'b00, 2'b00};
    vt[1] = '{M_SQ20,    0,   0, {7'd0,  7'd0},  {4'd5,  4'd5},  2'b00, 2'b00};
    vt[2] = '{M_SQ120,   0,   0, {7'd0,  7'd0},  {4'd0,  4'd0},  2'b00, 2'b11};
    vt[3] = '{M_C50,     0,   0, {7'd0,  7'd0},  {4'd15, 4'd15}, 2'b11, 2'b00};
    vt[4] = '{M_FLAT,  125, 200, {7'd70, 7'd0},  {4'd15, 4'd15}, 2'b00, 2'b00};
    r0 = int'($urandom_range(250, 121));
    r1 = int'($urandom_range(250, 121));
    vt[5] = '{M_FLAT, r0, r1, {7'(exp_dc(r1)), 7'(exp_dc(r0))}, {4'd15, 4'd15}, 2'b00, 2'b00};

    // Reset and IDLE behaviour, including reset overriding find_setting mid-measurement.
    mode = M_FLAT; base = '{150, 150, 150, 150};
    rst = 1'b1; sample_en = 1'b1; find_setting = 1'b0; rand_adc = '0;
    tick(2);
    chk("rst_led_en", led2, 0);    chk("rst_dc_comp", dc2, 0);   chk("rst_pga", pga2, 0);
    chk("rst_busy", busy2, 0);     chk("rst_cal_done", done2, 0); chk("rst_ch_valid", vld2, 0);
    chk("rst_ch_dc", chdc2, 0);    chk("rst_ch_pga", chpga2, 0);  chk("rst_ch_sat", sat2, 0);
    chk("rst_ch_clip0", clip2, 0);
    rst = 1'b0; tick(3);
    chk("idle_busy", busy2, 0); chk("idle_led_en", led2, 0);
    find_setting = 1'b1; tick(); find_setting = 1'b0;
    chk("start_busy", busy2, 1); chk("start_led_en", led2, 1);
    tick(6);
    rst = 1'b1; find_setting = 1'b1; tick(2);
    chk("midmeas_rst_busy", busy2, 0); chk("midmeas_rst_led_en", led2, 0);
    chk("midmeas_rst_dc", dc2, 0);     chk("midmeas_rst_pga", pga2, 0);
    rst = 1'b0; find_setting = 1'b0; tick(4);
    chk("no_restart_busy", busy2, 0); chk("no_restart_led_en", led2, 0);

    // Calibration scenarios.
    for (int k = 0; k < 6; k++) begin
      mode = vt[k].mode; base[0] = vt[k].b0; base[1] = vt[k].b1;
      sample_en = 1'b1;
      start_cal();
      wait_done(1'b0, ok);
      chk($sformatf("v%0d_busy", k), busy2, 0);
      chk($sformatf("v%0d_ch_dc", k), chdc2, vt[k].dc);
      chk($sformatf("v%0d_ch_pga", k), chpga2, vt[k].pga);
      chk($sformatf("v%0d_ch_sat", k), sat2, vt[k].sat);
      chk($sformatf("v%0d_ch_clip0", k), clip2, vt[k].clip);
    end

    // Operation with random samples; slot 3 never strobes sample_en.
    mode = M_RAND;
    for (int t = 0; t < SLOT * 12; t++) begin
      slot = t / SLOT; pos = t % SLOT; c = slot % 2;
      if (pos == 0) begin
        acc_q.delete();
        chk("op_dc_comp", dc2, vt[5].dc[c*7 +: 7]);
        chk("op_pga_gain", pga2, vt[5].pga[c*4 +: 4]);
      end
      chk("op_led_en", led2, 2'b01 << c);
      if (pos == SLOT - 1) begin
        exp_v = (acc_q.size() > 0);
        chk("op_ch_valid", vld2, exp_v);
        if (exp_v) begin
          chk("op_ch_id", id2, c);
          chk("op_ch_value", val2, acc_q[$]);
        end
      end else begin
        chk("op_ch_valid_quiet", vld2, 0);
      end
      sample_en = (slot == 3) ? 1'b0 : ($urandom_range(2, 0) != 0);
      rand_adc  = 8'($urandom);
      if (sample_en && pos >= SET && pos < SLOT - 1) acc_q.push_back(rand_adc);
      tick();
    end

    // Restart from OPERATE.
    mode = M_FLAT; base = '{150, 160, 140, 135}; sample_en = 1'b1;
    find_setting = 1'b1; tick(); find_setting = 1'b0;
    chk("restart_cal_done", done2, 0); chk("restart_busy", busy2, 1);
    chk("restart_led_en", led2, 1);    chk("restart_dc", dc2, 0);
    chk("restart_pga", pga2, 0);       chk("restart_ch_dc_kept", chdc2, vt[5].dc);

    // Four-channel regression.
    start_cal();
    wait_done(1'b1, ok);
    chk("ch4_ch_dc", chdc4, {7'd5, 7'd10, 7'd30, 7'd20});
    chk("ch4_ch_pga", chpga4, {4{4'd15}});
    chk("ch4_ch_sat", sat4, 0);
    chk("ch4_ch_clip0", clip4, 0);
    chk("ch4_busy", busy4, 0);
    for (int s = 0; s < 8; s++) begin
      chk("ch4_led_en", led4, 4'b0001 << (s % 4));
      chk("ch4_dc_comp", dc4, chdc4[(s % 4)*7 +: 7]);
      tick(SLOT - 1);
      chk("ch4_ch_valid", vld4, 1);
      chk("ch4_ch_id", id4, s % 4);
      chk("ch4_ch_value", val4, 130);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_led_calibrator.md
Name: multi_led_calibrator

Overview:
- N-channel successor to the two-LED (RED/IR) optical front-end controller.
- Sequentially calibrates DC compensation and PGA gain for each LED channel, then time-multiplexes the LEDs in operation mode, applying the stored per-channel settings and capturing one ADC sample per slot.
- Sits between the 8-bit ADC interface and the analog front-end controls (LED enables, DC comp DAC, PGA).
- Adds window-based min/max measurement, saturation and iteration-limit handling, and per-channel status flags.

Parameters:
- NUM_CH, 2, number of LED channels.
- ADC_W, 8, ADC sample width.
- DC_W, 7, DC compensation code width.
- PGA_W, 4, PGA gain code width.
- SETTLE_CYC, 4, cycles ignored after any LED, DC or PGA change.
- WIN_SAMPLES, 8, accepted samples per min/max window.
- SLOT_CYC, 10, operation dwell per channel (must exceed SETTLE_CYC).
- TARGET_LO, 120, lower bound of the DC band.
- TARGET_HI, 130, upper bound of the DC band.
- CLIP_LO, 10, clip threshold, low side.
- CLIP_HI, 245, clip threshold, high side.

Ports:
- CLK  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ADC  in  ADC_W  ADC sample.
- sample_en  in  1  ADC sample valid strobe.
- find_setting  in  1  start/restart calibration pulse.
- led_en  out  NUM_CH  one-hot LED enable.
- dc_comp  out  DC_W  applied DC compensation code.
- pga_gain  out  PGA_W  applied PGA gain.
- busy  out  1  calibration in progress.
- cal_done  out  1  all channels calibrated, operation active.
- ch_valid  out  1  one-cycle pulse, new operation sample.
- ch_id  out  $clog2(NUM_CH)  channel of ch_valid.
- ch_value  out  ADC_W  captured sample.
- ch_dc  out  NUM_CH*DC_W  stored DC codes, channel 0 in LSBs.
- ch_pga  out  NUM_CH*PGA_W  stored gains.
- ch_sat  out  NUM_CH  DC search saturated or iteration cap hit.
- ch_clip0  out  NUM_CH  channel clipped at gain 0.

Behaviour:
- One clock, CLK. Reset rst is synchronous, active-high. All state is registered.
- Reset wins over find_setting. Reset value of every output and stored register is 0; state returns to IDLE.
- find_setting asserted in any state except reset, including mid-calibration or OPERATE:
  - next cycle: state SETTLE, channel 0, dc_comp=0, pga_gain=0, led_en=1, busy=1, cal_done=0;
  - the ch_sat, ch_clip0, ch_dc and ch_pga entries for each channel are overwritten when that channel is re-calibrated.
- States:
  - IDLE: led_en=0, busy=0.
  - SETTLE: count SETTLE_CYC cycles, then go to MEAS. sample_en is ignored while in SETTLE.
  - MEAS: track min/max over WIN_SAMPLES sample_en-qualified samples. After the last sample, avg=(max+min)>>1 computed at ADC_W+1 bits; go to DC_ADJ or PGA_ADJ according to the phase flag.
  - DC_ADJ:
    - avg<TARGET_LO: dc_comp-1.
    - avg>TARGET_HI: dc_comp+1.
    - Either adjustment returns to SETTLE.
    - In band: store dc_comp in ch_dc, set pga_gain=0, phase=PGA, go to SETTLE.
    - A step below 0 or above 2^DC_W-1: do not step, set ch_sat, store the current code, enter the PGA phase.
    - 2^DC_W adjustments without reaching the band: same handling as saturation.
  - PGA_ADJ:
    - clip (min<CLIP_LO or max>CLIP_HI): store gain-1. At gain 0, store 0 and set ch_clip0.
    - No clip and gain==2^PGA_W-1: store the maximum gain.
    - Otherwise gain+1, then SETTLE.
    - After storing, go to NEXT_CH.
  - NEXT_CH:
    - If the channel is not the last: increment the channel, rotate led_en, dc_comp=0, pga_gain=0, phase=DC, go to SETTLE.
    - After the last channel: go to OPERATE, busy=0, cal_done=1.
  - OPERATE:
    - Round-robin slots of SLOT_CYC cycles starting at channel 0.
    - During a slot: led_en one-hot for the slot channel; dc_comp/pga_gain driven from the stored values on the slot's first cycle.
    - Samples with sample_en in the first SETTLE_CYC cycles of a slot are discarded.
    - The last accepted sample is latched.
    - On the final slot cycle, pulse ch_valid with ch_id/ch_value if at least one sample was accepted; otherwise no pulse.
    - ch_value holds between pulses.
- Min/max registers reset to (max code, 0) at the start of each MEAS.
- sample_en deasserted stalls the MEAS window indefinitely; there is no timeout.

Decomposition:
- Package multi_led_cal_pkg:
  - state enum (IDLE, SETTLE, MEAS, DC_ADJ, PGA_ADJ, NEXT_CH, OPERATE);
  - phase enum (DC, PGA);
  - average function.
- Sub-module window_minmax:
  - inputs clear, sample_en, ADC;
  - outputs min, max, done after WIN_SAMPLES;
  - parametrised by ADC_W and WIN_SAMPLES.

Test Plan:
- Reset/IDLE: rst high 2 cycles, mid-MEAS, with find_setting also high -> all outputs 0, IDLE; no restart until find_setting pulses after rst drops.
- DC convergence: ADC model = 150 - dc_comp, flat, sample_en every cycle; PGA never clips -> ch_dc[0]=ch_dc[1]=20, ch_pga=15 each, ch_sat=0, cal_done=1, busy=0.
- PGA clip: ADC square wave 125 ± 20*pga_gain (DC in band) -> gain 6 gives min 5 (clip), stored ch_pga=5. Same model with swing 125 ± 120 at gain 0 -> ch_pga=0, ch_clip0=1.
- DC saturation: ADC constant 50 -> dc_comp never decrements below 0, ch_sat=1, ch_dc=0, calibration proceeds to channel 1.
- Operation: after calibration with NUM_CH=2:
  - led_en alternates 01/10 every 10 cycles;
  - ch_valid pulses on each slot's cycle 10 with ch_id alternating 0/1;
  - dc_comp/pga_gain match the stored values per slot;
  - a slot with sample_en low throughout produces no pulse.
- Restart: find_setting pulse during OPERATE -> cal_done=0 and busy=1 next cycle, led_en=01, dc_comp=0, pga_gain=0. NUM_CH=4 regression -> four sequential calibrations, round-robin 0..3.
